// File: rtl/ddr_axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_axi_pkg : shared AXI burst constants and AR types for DDRSubsys  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ddr_axi_pkg;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    localparam int DDR_MAX_BEATS = 16;

    typedef struct packed {
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
    } ar_beat_t;

    // Sub-burst arlen for a remaining beat count (rem is 1..256).
    function automatic logic [3:0] sub_len(input logic [8:0] rem);
        return (rem > 9'(DDR_MAX_BEATS)) ? 4'hF : 4'(rem - 9'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_flag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_flag_fifo : 1-bit synchronous FIFO of per-sub-burst final flags  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ddr_flag_fifo #(
    parameter int MAX_OUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_dout,
    output logic o_full,
    output logic o_afull,
    output logic o_empty
);

    localparam int PTR_W = $clog2(MAX_OUT);

    logic [MAX_OUT-1:0] r_mem;
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic [PTR_W:0]     w_count;

    // Extra pointer bit distinguishes full from empty.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = (w_count == (PTR_W+1)'(MAX_OUT));
    assign o_afull = (w_count == (PTR_W+1)'(MAX_OUT - 1));
    assign o_empty = (w_count == '0);
    assign o_dout  = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
                r_wr_ptr                   <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddr_ar_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_ar_splitter : splits 256-beat AXI read bursts into 16-beat       |
// | sub-bursts for DDRSubsys and merges rlast on the return path. Rev 1.0|
// +----------------------------------------------------------------------+
module ddr_ar_splitter
    import ddr_axi_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 8,
    parameter int MAX_OUT = 8
) (
    input  logic              acr_clk,
    input  logic              acr_rst,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arlock,
    input  logic [3:0]        s_arcache,
    input  logic [2:0]        s_arprot,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   axi_arid,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [3:0]        axi_arlen,
    output logic [2:0]        axi_arsize,
    output logic [1:0]        axi_arburst,
    output logic              axi_arlock,
    output logic [3:0]        axi_arcache,
    output logic [2:0]        axi_arprot,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [ID_W-1:0]   axi_rid,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    input  logic              axi_rvalid,
    output logic              axi_rready
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ID_W-1:0]   r_id, w_id_nxt;
    ar_beat_t          r_beat, w_beat_nxt;
    logic [8:0]        r_rem, w_rem_nxt;
    logic [3:0]        r_len, w_len_nxt;
    logic              r_arvalid, w_arvalid_nxt;

    logic              w_ar_hs, w_final, w_push, w_pop;
    logic              w_fifo_head, w_fifo_full, w_fifo_afull, w_fifo_empty;
    logic              w_full_nxt;
    logic [ADDR_W-1:0] w_size_mask, w_incr_addr;

    assign w_ar_hs = r_arvalid & axi_arready;
    assign w_final = (r_rem <= 9'(DDR_MAX_BEATS));
    assign w_pop   = axi_rvalid & s_rready & axi_rlast;

    // Align down to the beat size, then step one full sub-burst.
    assign w_size_mask = (ADDR_W'(1) << r_beat.size) - ADDR_W'(1);
    assign w_incr_addr = (r_addr & ~w_size_mask) + (ADDR_W'(DDR_MAX_BEATS) << r_beat.size);

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_id_nxt    = r_id;
        w_beat_nxt  = r_beat;
        w_rem_nxt   = r_rem;
        w_len_nxt   = r_len;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_arvalid) begin
                    w_addr_nxt  = s_araddr;
                    w_id_nxt    = s_arid;
                    w_beat_nxt  = '{size: s_arsize, burst: s_arburst, lock: s_arlock,
                                    cache: s_arcache, prot: s_arprot};
                    w_rem_nxt   = {1'b0, s_arlen} + 9'd1;
                    w_len_nxt   = sub_len({1'b0, s_arlen} + 9'd1);
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_ar_hs) begin
                    w_push = 1'b1;
                    if (w_final) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_rem_nxt  = r_rem - 9'(DDR_MAX_BEATS);
                        w_len_nxt  = sub_len(r_rem - 9'(DDR_MAX_BEATS));
                        w_addr_nxt = (r_beat.burst == INCR) ? w_incr_addr : r_addr;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Valid is only raised when the flag FIFO will have room next cycle,
    // and once raised it is held until the handshake.
    always_comb begin
        w_full_nxt    = w_fifo_full ? (!w_pop || w_push)
                                    : (w_fifo_afull && w_push && !w_pop);
        w_arvalid_nxt = (w_state_nxt == ST_ISSUE) &&
                        ((r_arvalid && !axi_arready) || !w_full_nxt);
    end

    always_ff @(posedge acr_clk or negedge acr_rst) begin
        if (!acr_rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_id      <= '0;
            r_beat    <= '0;
            r_rem     <= '0;
            r_len     <= '0;
            r_arvalid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_id      <= w_id_nxt;
            r_beat    <= w_beat_nxt;
            r_rem     <= w_rem_nxt;
            r_len     <= w_len_nxt;
            r_arvalid <= w_arvalid_nxt;
        end
    end

    ddr_flag_fifo #(
        .MAX_OUT (MAX_OUT)
    ) u_flag_fifo (
        .clk     (acr_clk),
        .rst_n   (acr_rst),
        .i_push  (w_push),
        .i_din   (w_final),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_afull (w_fifo_afull),
        .o_empty (w_fifo_empty)
    );

    assign s_arready   = (r_state == ST_IDLE);
    assign axi_arid    = r_id;
    assign axi_araddr  = r_addr;
    assign axi_arlen   = r_len;
    assign axi_arsize  = r_beat.size;
    assign axi_arburst = r_beat.burst;
    assign axi_arlock  = r_beat.lock;
    assign axi_arcache = r_beat.cache;
    assign axi_arprot  = r_beat.prot;
    assign axi_arvalid = r_arvalid;

    assign s_rvalid   = axi_rvalid;
    assign axi_rready = s_rready;
    assign s_rid      = axi_rid;
    assign s_rdata    = axi_rdata;
    assign s_rresp    = axi_rresp;
    assign s_rlast    = axi_rlast & w_fifo_head;

    a_r_needs_flag: assert property (@(posedge acr_clk) disable iff (!acr_rst)
                                     axi_rvalid |-> !w_fifo_empty);

endmodule

`default_nettype wire

// File: tb/tb_ddr_ar_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ddr_ar_splitter : scoreboard bench for the AR burst splitter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ddr_ar_splitter;

    logic        acr_clk = 1'b0;
    logic        acr_rst = 1'b0;
    logic [7:0]  s_arid = '0;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic [2:0]  s_arsize = '0;
    logic [1:0]  s_arburst = '0;
    logic        s_arlock = 1'b0;
    logic [3:0]  s_arcache = '0;
    logic [2:0]  s_arprot = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [7:0]  s_rid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast, s_rvalid;
    logic        s_rready = 1'b1;
    logic [7:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [3:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arlock;
    logic [3:0]  axi_arcache;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready = 1'b1;
    logic [7:0]  axi_rid = '0;
    logic [63:0] axi_rdata = '0;
    logic [1:0]  axi_rresp = '0;
    logic        axi_rlast = 1'b0;
    logic        axi_rvalid = 1'b0;
    logic        axi_rready;

    always #5 acr_clk = ~acr_clk;

    ddr_ar_splitter #(
        .ADDR_W(32), .DATA_W(64), .ID_W(8), .MAX_OUT(8)
    ) dut (
        .acr_clk(acr_clk), .acr_rst(acr_rst),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
        .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [7:0]  id;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;
    typedef struct packed { logic [7:0] id; logic [3:0] len; } ddr_t;
    typedef struct packed { logic last; logic [7:0] id; } r_t;

    ar_t   exp_ar[$];
    r_t    exp_r[$];
    ddr_t  ddr_q[$];
    ar_t   e_ar;
    r_t    e_r;
    int    checks = 0;
    int    errors = 0;
    int    ar_hs = 0;
    int    r_sub_done = 0;
    int    r_budget = 1 << 30;
    logic [63:0] r_seq = '0;
    logic [63:0] exp_seq = '0;
    logic        sb_lock = 1'b0;
    logic [3:0]  sb_cache = 4'h0;
    logic [2:0]  sb_prot = 3'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic exp_sub(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                           input logic [2:0] size, input logic [1:0] burst);
        exp_ar.push_back('{addr: addr, len: len, id: id, size: size, burst: burst});
    endtask

    task automatic exp_beats(input logic [7:0] id, input int n);
        for (int b = 0; b < n; b++) exp_r.push_back('{last: (b == n - 1), id: id});
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(posedge acr_clk); #1;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arlock = sb_lock; s_arcache = sb_cache; s_arprot = sb_prot; s_arvalid = 1'b1;
        while (!s_arready && n < 200) begin
            @(posedge acr_clk); #1; n++;
        end
        if (!s_arready) check("ar_accept_timeout", 0, 1);
        @(posedge acr_clk); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (n < budget && !(exp_ar.size() == 0 && exp_r.size() == 0 && ddr_q.size() == 0
                               && s_arready && !axi_arvalid)) begin
            @(negedge acr_clk); n++;
        end
        if (n >= budget) check("drain_timeout", 0, 1);
    endtask

    task automatic wait_ar_hs(input int target, input int budget);
        int n = 0;
        while (n < budget && ar_hs < target) begin
            @(negedge acr_clk); n++;
        end
        if (ar_hs < target) check("ar_hs_timeout", 64'(ar_hs), 64'(target));
    endtask

    task automatic wait_rsub(input int target, input int budget);
        int n = 0;
        while (n < budget && r_sub_done < target) begin
            @(posedge acr_clk); #1; n++;
        end
        if (r_sub_done < target) check("r_sub_timeout", 64'(r_sub_done), 64'(target));
    endtask

    // DDRSubsys model: records accepted sub-bursts, replays them on R in order.
    always @(posedge acr_clk)
        if (acr_rst && axi_arvalid && axi_arready) ddr_q.push_back('{id: axi_arid, len: axi_arlen});

    initial begin
        ddr_t ent;
        forever begin
            @(posedge acr_clk); #1;
            if (acr_rst && ddr_q.size() > 0 && r_budget > 0) begin
                ent = ddr_q.pop_front();
                r_budget--;
                for (int b = 0; b <= int'(ent.len); b++) begin
                    axi_rvalid = 1'b1; axi_rid = ent.id; axi_rdata = r_seq;
                    axi_rresp = r_seq[1:0]; axi_rlast = (b == int'(ent.len));
                    @(posedge acr_clk);
                    r_seq++;
                    #1;
                end
                axi_rvalid = 1'b0; axi_rlast = 1'b0;
                r_sub_done++;
            end
        end
    end

    // Scoreboard monitor: sampled mid-cycle, one entry per upcoming handshake.
    always @(negedge acr_clk) begin
        if (acr_rst) begin
            if (axi_arvalid && axi_arready) begin
                ar_hs++;
                if (exp_ar.size() == 0) begin
                    check("ar_unexpected", {32'h0, axi_araddr}, 64'hFFFF_FFFF);
                end else begin
                    e_ar = exp_ar.pop_front();
                    check("ar_addr", 64'(axi_araddr), 64'(e_ar.addr));
                    check("ar_len", 64'(axi_arlen), 64'(e_ar.len));
                    check("ar_id", 64'(axi_arid), 64'(e_ar.id));
                    check("ar_size_burst", 64'({axi_arsize, axi_arburst}), 64'({e_ar.size, e_ar.burst}));
                    check("ar_sideband", 64'({axi_arlock, axi_arcache, axi_arprot}),
                          64'({sb_lock, sb_cache, sb_prot}));
                end
            end
            if (s_rvalid && s_rready) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", s_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e_r = exp_r.pop_front();
                    check("r_last", 64'(s_rlast), 64'(e_r.last));
                    check("r_id", 64'(s_rid), 64'(e_r.id));
                    check("r_data", s_rdata, exp_seq);
                    check("r_resp", 64'(s_rresp), 64'(exp_seq[1:0]));
                end
                exp_seq++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge acr_clk);
        #1;
        check("rst_arvalid", 64'(axi_arvalid), 0);
        acr_rst = 1'b1;
        #1;
        check("rst_arready", 64'(s_arready), 1);
        check("rst_araddr", 64'(axi_araddr), 0);
        check("rst_arlen_id", 64'({axi_arlen, axi_arid}), 0);
        check("rst_rvalid", 64'(s_rvalid), 0);

        // INCR aligned, 40 beats -> 16/16/8
        sb_lock = 1'b0; sb_cache = 4'h3; sb_prot = 3'h2;
        exp_sub(32'h1000, 4'd15, 8'h11, 3'd3, 2'b01);
        exp_sub(32'h1080, 4'd15, 8'h11, 3'd3, 2'b01);
        exp_sub(32'h1100, 4'd7,  8'h11, 3'd3, 2'b01);
        exp_beats(8'h11, 40);
        send_ar(8'h11, 32'h1000, 8'd39, 3'd3, 2'b01);
        wait_drain(500);

        // INCR unaligned, 17 beats
        sb_lock = 1'b1; sb_cache = 4'hA; sb_prot = 3'h5;
        exp_sub(32'h1004, 4'd15, 8'h22, 3'd3, 2'b01);
        exp_sub(32'h1080, 4'd0,  8'h22, 3'd3, 2'b01);
        exp_beats(8'h22, 17);
        send_ar(8'h22, 32'h1004, 8'd16, 3'd3, 2'b01);
        wait_drain(500);

        // FIXED 32 beats, WRAP 8 beats, single beat
        exp_sub(32'h2000, 4'd15, 8'h05, 3'd2, 2'b00);
        exp_sub(32'h2000, 4'd15, 8'h05, 3'd2, 2'b00);
        exp_beats(8'h05, 32);
        send_ar(8'h05, 32'h2000, 8'd31, 3'd2, 2'b00);
        wait_drain(500);
        exp_sub(32'h3010, 4'd7, 8'h06, 3'd3, 2'b10);
        exp_beats(8'h06, 8);
        send_ar(8'h06, 32'h3010, 8'd7, 3'd3, 2'b10);
        wait_drain(500);
        exp_sub(32'h8000, 4'd0, 8'h07, 3'd3, 2'b01);
        exp_beats(8'h07, 1);
        send_ar(8'h07, 32'h8000, 8'd0, 3'd3, 2'b01);
        wait_drain(500);

        // AR backpressure: fields hold while ready is low
        axi_arready = 1'b0;
        exp_sub(32'h4000, 4'd15, 8'h44, 3'd3, 2'b01);
        exp_sub(32'h4080, 4'd4,  8'h44, 3'd3, 2'b01);
        exp_beats(8'h44, 21);
        send_ar(8'h44, 32'h4000, 8'd20, 3'd3, 2'b01);
        for (int i = 0; i < 5; i++) begin
            @(negedge acr_clk);
            check("stall_valid_ready", 64'({axi_arvalid, s_arready}), 64'(2'b10));
            check("stall_addr_len", 64'({axi_araddr, axi_arlen}), 64'({32'h4000, 4'd15}));
        end
        @(posedge acr_clk); #1;
        axi_arready = 1'b1;
        @(negedge acr_clk);
        check("s_arready_mid", 64'(s_arready), 0);
        wait_drain(500);

        // Outstanding limit: R stalled, 256-beat burst
        r_budget = 0;
        base = ar_hs;
        for (int k = 0; k < 16; k++) exp_sub(32'h5000 + 32'(k) * 32'h80, 4'd15, 8'h55, 3'd3, 2'b01);
        exp_beats(8'h55, 256);
        send_ar(8'h55, 32'h5000, 8'd255, 3'd3, 2'b01);
        wait_ar_hs(base + 8, 200);
        repeat (6) @(negedge acr_clk);
        check("full_ar_count", 64'(ar_hs - base), 8);
        check("full_arvalid", 64'(axi_arvalid), 0);
        base = r_sub_done;
        r_budget = 1;
        wait_rsub(base + 1, 200);
        @(negedge acr_clk);
        check("ninth_issue", 64'(axi_arvalid), 1);
        r_budget = 1 << 30;
        wait_drain(2000);

        // Reset during ISSUE with sub-bursts outstanding
        r_budget = 0;
        base = ar_hs;
        for (int k = 0; k < 16; k++) exp_sub(32'h6000 + 32'(k) * 32'h80, 4'd15, 8'h66, 3'd3, 2'b01);
        send_ar(8'h66, 32'h6000, 8'd255, 3'd3, 2'b01);
        wait_ar_hs(base + 3, 200);
        @(posedge acr_clk); #1;
        check("pre_reset_valid", 64'(axi_arvalid), 1);
        acr_rst = 1'b0;
        #1;
        check("reset_arvalid", 64'(axi_arvalid), 0);
        exp_ar.delete(); exp_r.delete(); ddr_q.delete();
        repeat (2) @(posedge acr_clk);
        #1;
        acr_rst = 1'b1;
        r_budget = 1 << 30;
        #1;
        check("post_reset_arready", 64'(s_arready), 1);
        check("post_reset_fifo_empty", 64'(dut.w_fifo_empty), 1);
        exp_sub(32'h7000, 4'd3, 8'h77, 3'd3, 2'b01);
        exp_beats(8'h77, 4);
        send_ar(8'h77, 32'h7000, 8'd3, 3'd3, 2'b01);
        wait_drain(500);

        repeat (5) @(posedge acr_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
